// File: rtl/usequencer.sv
// Microprogram sequencer: writable control store, MPC and next-address logic.
// Optional step counter output USEQ_STEPS_OUT is enabled by defining USEQ_STEP_COUNT_EN.
module usequencer #(
    parameter int MIR_BUS_WIDTH  = 41,
    parameter int ADDR_BUS_WIDTH = 11,
    parameter int COND_BUS_WIDTH = 3,
    parameter int IR_BUS_WIDTH   = 32
) (
    input  logic                      USEQ_CLOCK_50,
    input  logic                      USEQ_RESET_InLow,
    input  logic                      USEQ_LOAD_VALID_IN,
    output logic                      USEQ_LOAD_READY_OUT,
    input  logic [ADDR_BUS_WIDTH-1:0] USEQ_LOAD_ADDR_IN,
    input  logic [MIR_BUS_WIDTH-1:0]  USEQ_LOAD_DATA_IN,
    input  logic                      USEQ_RUN_IN,
    input  logic                      USEQ_HALT_IN,
    input  logic                      USEQ_N_IN,
    input  logic                      USEQ_Z_IN,
    input  logic                      USEQ_V_IN,
    input  logic                      USEQ_C_IN,
    input  logic [IR_BUS_WIDTH-1:0]   USEQ_IR_IN,
    input  logic                      USEQ_MEM_DONE_IN,
    output logic [MIR_BUS_WIDTH-1:0]  USEQ_MICRO_OUT,
    output logic                      USEQ_VALID_OUT,
    output logic [ADDR_BUS_WIDTH-1:0] USEQ_MPC_OUT,
    output logic                      USEQ_BUSY_OUT
`ifdef USEQ_STEP_COUNT_EN
    ,
    output logic [15:0]               USEQ_STEPS_OUT
`endif
);

    localparam int COND_LSB = ADDR_BUS_WIDTH;
    localparam int WR_BIT   = COND_LSB + COND_BUS_WIDTH + 4;
    localparam int RD_BIT   = WR_BIT + 1;

    typedef enum logic [1:0] {IDLE, FETCH, EXEC} state_t;

    state_t                    state;
    logic [ADDR_BUS_WIDTH-1:0] mpc;
    logic [ADDR_BUS_WIDTH-1:0] mpc_inc;
    logic [ADDR_BUS_WIDTH-1:0] next_mpc;
    logic [COND_BUS_WIDTH-1:0] cond;
    logic [ADDR_BUS_WIDTH-1:0] jump;
    logic                      take;
    logic                      stall;
    logic [MIR_BUS_WIDTH-1:0]  cs [0:(1<<ADDR_BUS_WIDTH)-1];

    assign cond  = USEQ_MICRO_OUT[COND_LSB +: COND_BUS_WIDTH];
    assign jump  = USEQ_MICRO_OUT[ADDR_BUS_WIDTH-1:0];
    assign stall = (USEQ_MICRO_OUT[RD_BIT] | USEQ_MICRO_OUT[WR_BIT]) & ~USEQ_MEM_DONE_IN;
    assign USEQ_MPC_OUT = mpc;

    // Only bits 31:30, 24:19 and 13 of IR steer sequencing.
    logic unused_ir;
    assign unused_ir = &{1'b0, USEQ_IR_IN[29:25], USEQ_IR_IN[18:14], USEQ_IR_IN[12:0]};

    always_comb begin
        mpc_inc  = mpc + {{(ADDR_BUS_WIDTH-1){1'b0}}, 1'b1};
        take     = 1'b0;
        next_mpc = mpc_inc;
        case (cond)
            3'b001:  take = USEQ_N_IN;
            3'b010:  take = USEQ_Z_IN;
            3'b011:  take = USEQ_V_IN;
            3'b100:  take = USEQ_C_IN;
            3'b101:  take = USEQ_IR_IN[13];
            3'b111:  take = 1'b1;
            default: take = 1'b0;
        endcase
        if (cond == 3'b110)
            next_mpc = {1'b1, USEQ_IR_IN[31:30], USEQ_IR_IN[24:19], 2'b00};
        else if (take)
            next_mpc = jump;
    end

    // Control store has no reset so its contents survive a reset.
    always_ff @(posedge USEQ_CLOCK_50) begin
        if (USEQ_RESET_InLow && state == IDLE && USEQ_LOAD_VALID_IN)
            cs[USEQ_LOAD_ADDR_IN] <= USEQ_LOAD_DATA_IN;
    end

    always_ff @(posedge USEQ_CLOCK_50) begin
        if (!USEQ_RESET_InLow) begin
            state               <= IDLE;
            mpc                 <= '0;
            USEQ_MICRO_OUT      <= '0;
            USEQ_VALID_OUT      <= 1'b0;
            USEQ_BUSY_OUT       <= 1'b0;
            USEQ_LOAD_READY_OUT <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (USEQ_RUN_IN) begin
                        mpc                 <= '0;
                        state               <= FETCH;
                        USEQ_BUSY_OUT       <= 1'b1;
                        USEQ_LOAD_READY_OUT <= 1'b0;
                    end
                end
                FETCH: begin
                    USEQ_MICRO_OUT <= cs[mpc];
                    USEQ_VALID_OUT <= 1'b1;
                    state          <= EXEC;
                end
                EXEC: begin
                    if (!stall) begin
                        mpc            <= next_mpc;
                        USEQ_VALID_OUT <= 1'b0;
                        if (USEQ_HALT_IN) begin
                            state               <= IDLE;
                            USEQ_BUSY_OUT       <= 1'b0;
                            USEQ_LOAD_READY_OUT <= 1'b1;
                        end else begin
                            state <= FETCH;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef USEQ_STEP_COUNT_EN
    always_ff @(posedge USEQ_CLOCK_50) begin
        if (!USEQ_RESET_InLow)
            USEQ_STEPS_OUT <= '0;
        else if (state == IDLE && USEQ_RUN_IN)
            USEQ_STEPS_OUT <= '0;
        else if (state == EXEC && !stall && USEQ_STEPS_OUT != 16'hFFFF)
            USEQ_STEPS_OUT <= USEQ_STEPS_OUT + 16'd1;
    end
`endif

endmodule
